// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a newd/donetx handshake.
// newd is released on the donetx rising edge so the transmitter never sends a frame twice.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          newd,
    output logic [7:0]    dintx,
    input  logic          donetx,
    output logic          busy
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          donetx_q;
    logic          push;
    logic          pop;
    logic          donetx_rise;
    logic          newd_d;
    logic          busy_d;
    logic [LW-1:0] level_d;

    assign push        = wr_en & ~full;
    assign donetx_rise = donetx & ~donetx_q;
    assign level_d     = level + LW'(push) - LW'(pop);

    // Handshake next-state: pop on IDLE->SEND, drop newd on the donetx rise.
    always_comb begin
        state_d = state_q;
        newd_d  = newd;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !donetx) begin
                    state_d = SEND;
                    newd_d  = 1'b1;
                    pop     = 1'b1;
                end
            end
            SEND: begin
                if (donetx_rise) begin
                    state_d = RELEASE;
                    newd_d  = 1'b0;
                end
            end
            RELEASE: begin
                if (!donetx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                newd_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            newd     <= 1'b0;
            busy     <= 1'b0;
            donetx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            newd     <= newd_d;
            busy     <= busy_d;
            donetx_q <= donetx;
        end
    end

    // Pointers, occupancy and flags; full/empty track the next level so they match level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            dintx    <= 8'h00;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                dintx <= mem[rptr];
                rptr  <= rptr + AW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            level <= level_d;
            empty <= (level_d == '0);
            full  <= (level_d == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table plus multi-cycle handshake sequences.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          newd;
    logic [7:0]    dintx;
    logic          donetx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .newd     (newd),
        .dintx    (dintx),
        .donetx   (donetx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  wd;
        logic        dtx;
        logic        e_newd;
        logic [7:0]  e_dintx;
        logic [AW:0] e_level;
        logic        e_empty;
        logic        e_full;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: take the offered byte, hold, pulse donetx for three cycles.
    task automatic tx_frame(output logic [7:0] b);
        int w;
        w = 0;
        while (!newd && w < 64) begin
            step();
            w++;
        end
        chk("newd_wait", 32'(newd), 32'(1));
        b = dintx;
        step();
        chk("newd_hold", 32'(newd), 32'(1));
        chk("dintx_hold", 32'(dintx), 32'(b));
        donetx = 1'b1;
        repeat (3) begin
            step();
            chk("newd_low_while_done", 32'(newd), 32'(0));
        end
        donetx = 1'b0;
        step();
        chk("busy_after_frame", 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;

        //                we    wd     dtx   newd  dintx  level  empty full  busy
        vq.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd0 + 5'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 5'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 5'd0, 1'b1, 1'b0, 1'b0});

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        donetx  = 1'b0;
        repeat (3) step();

        chk("rst_newd", 32'(newd), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_dintx", 32'(dintx), 32'(8'h00));
        rst = 1'b1;

        // Per-cycle vectors: single byte, write/pop collision, donetx high in IDLE.
        foreach (vq[i]) begin
            wr_en   = vq[i].we;
            wr_data = vq[i].wd;
            donetx  = vq[i].dtx;
            step();
            chk($sformatf("vec%0d_newd", i), 32'(newd), 32'(vq[i].e_newd));
            chk($sformatf("vec%0d_dintx", i), 32'(dintx), 32'(vq[i].e_dintx));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vq[i].e_level));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vq[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vq[i].e_full));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(0));
        end
        wr_en  = 1'b0;
        donetx = 1'b0;

        // Burst 01..05 back to back, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("burst_level", 32'(level), 32'(4));
        chk("burst_first_newd", 32'(newd), 32'(1));
        for (int i = 1; i <= 5; i++) begin
            tx_frame(b);
            chk("burst_order", 32'(b), 32'(i));
        end
        step();
        chk("burst_empty", 32'(empty), 32'(1));
        chk("burst_busy", 32'(busy), 32'(0));

        // Fill past capacity with donetx stuck low.
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h40 + 8'(i);
            step();
            if (i == DEPTH - 1) begin
                chk("fill_level_dm1", 32'(level), 32'(DEPTH - 1));
                chk("fill_not_full", 32'(full), 32'(0));
                chk("fill_no_ovf_yet", 32'(overflow), 32'(0));
            end
            if (i == DEPTH) begin
                chk("fill_full", 32'(full), 32'(1));
                chk("fill_level_d", 32'(level), 32'(DEPTH));
            end
        end
        wr_en = 1'b0;
        chk("ovf_set", 32'(overflow), 32'(1));
        chk("ovf_level", 32'(level), 32'(DEPTH));
        chk("ovf_empty", 32'(empty), 32'(0));
        chk("ovf_dintx", 32'(dintx), 32'(8'h40));
        tx_frame(b);
        chk("ovf_first", 32'(b), 32'(8'h40));
        // Write while full on the pop edge: still dropped.
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        chk("fullpop_level", 32'(level), 32'(DEPTH - 1));
        chk("fullpop_full", 32'(full), 32'(0));
        chk("fullpop_dintx", 32'(dintx), 32'(8'h41));
        for (int i = 1; i <= DEPTH; i++) begin
            tx_frame(b);
            chk("ovf_order", 32'(b), 32'(8'h40 + 8'(i)));
        end
        step();
        chk("ovf_drained_empty", 32'(empty), 32'(1));
        chk("ovf_drained_level", 32'(level), 32'(0));
        chk("ovf_sticky", 32'(overflow), 32'(1));

        // Pointer wrap: 3*DEPTH incrementing bytes in rounds of 8.
        for (int r = 0; r < (3 * DEPTH) / 8; r++) begin
            for (int j = 0; j < 8; j++) begin
                wr_en   = 1'b1;
                wr_data = 8'h60 + 8'(r * 8 + j);
                step();
            end
            wr_en = 1'b0;
            for (int j = 0; j < 8; j++) begin
                tx_frame(b);
                chk("wrap_order", 32'(b), 32'(8'h60 + 8'(r * 8 + j)));
            end
        end
        step();
        chk("wrap_empty", 32'(empty), 32'(1));

        // Reset during SEND with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'hC1 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("mid_newd", 32'(newd), 32'(1));
        chk("mid_level", 32'(level), 32'(3));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_newd", 32'(newd), 32'(0));
        chk("arst_level", 32'(level), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_overflow", 32'(overflow), 32'(0));
        step();
        rst = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_idle_newd", 32'(newd), 32'(0));
            chk("post_rst_idle_busy", 32'(busy), 32'(0));
        end
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        chk("post_rst_write_newd", 32'(newd), 32'(0));
        chk("post_rst_write_level", 32'(level), 32'(1));
        step();
        chk("post_rst_newd", 32'(newd), 32'(1));
        chk("post_rst_dintx", 32'(dintx), 32'(8'h3C));
        tx_frame(b);
        chk("post_rst_byte", 32'(b), 32'(8'h3C));
        step();
        chk("final_empty", 32'(empty), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
